arc4_ksa_top: RTL and testbench

- Top-level board wrapper (instantiated as task2) for the ARC4 key-scheduling stage.
- Out of reset, it initialises a 256x8 state array S to the identity permutation, then runs the ARC4 KSA with a 24-bit key built from the switches.
- Completion is reported on LEDR[0].
- The downstream PRGA/decrypt stages (later tasks) consume S.

---
 rtl/arc4_ksa_top.sv | 163 ++++++++++++++++
 tb/tb_arc4_ksa_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_ksa_top.sv
// rtl/arc4_ksa_top.sv - ARC4 key-scheduling (KSA) stage board wrapper
//
// Purpose: fills a 256x8 state array with the identity permutation, then
// runs the ARC4 key schedule over it using a 24-bit key {14'b0, SW}.
// The finished array is left in s_mem for the downstream PRGA stage.
//
// Ports:
//   CLOCK_50   in   1   system clock, rising edge
//   KEY        in   4   KEY[3] = synchronous active-high reset, KEY[2:0] unused
//   SW         in  10   key source, key = {14'b0, SW}
//   HEX0..HEX5 out  7   seven-segment (active-low), always blank
//   LEDR       out 10   LEDR[0] = done, LEDR[9:1] = 0
module arc4_ksa_top (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [9:0] LEDR
);

   typedef enum logic [2:0] {
      S_INIT,
      S_RD_I,
      S_WAIT_I,
      S_RD_J,
      S_WAIT_J,
      S_WR_I,
      S_WR_J,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [7:0] r_i;
   logic [7:0] r_j;
   logic [7:0] r_j_next;
   logic [7:0] r_si;
   logic [7:0] r_sj;
   logic [7:0] r_rdata;
   logic [1:0] r_k;
   logic       r_done;

   // State array: single port, synchronous write, registered read.
   logic [7:0] s_mem [0:255];

   logic        w_rst;
   logic [23:0] w_key;
   logic [7:0]  w_kb;
   logic [7:0]  w_addr;
   logic [7:0]  w_wdata;
   logic        w_we;
   logic        w_unused;

   assign w_rst    = KEY[3];
   assign w_key    = {14'b0, SW};
   assign w_unused = &{1'b0, KEY[2:0]};

   // Key byte selected by the wrapping 0,1,2 index.
   always_comb begin
      case (r_k)
         2'd0:    w_kb = w_key[23:16];
         2'd1:    w_kb = w_key[15:8];
         default: w_kb = w_key[7:0];
      endcase
   end

   // Memory port steering. Writes are suppressed while reset is held so an
   // abort never corrupts a location with a half-finished swap value.
   always_comb begin
      w_addr  = r_i;
      w_wdata = r_i;
      w_we    = 1'b0;
      case (r_state)
         S_INIT: w_we = 1'b1;
         S_RD_J: w_addr = r_j_next;
         S_WR_I: begin
            w_we    = 1'b1;
            w_wdata = r_sj;
         end
         S_WR_J: begin
            w_addr  = r_j;
            w_we    = 1'b1;
            w_wdata = r_si;
         end
         default: ;
      endcase
      if (w_rst) begin
         w_we = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (w_we) begin
         s_mem[w_addr] <= w_wdata;
      end
      r_rdata <= s_mem[w_addr];
   end

   // Key-schedule FSM. When i==j the two write states store the same byte
   // (si==sj) to the same address, so no special case is needed.
   always_ff @(posedge CLOCK_50) begin
      if (w_rst) begin
         r_state  <= S_INIT;
         r_i      <= 8'd0;
         r_j      <= 8'd0;
         r_k      <= 2'd0;
         r_j_next <= 8'd0;
         r_si     <= 8'd0;
         r_sj     <= 8'd0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               r_i <= r_i + 8'd1;
               if (r_i == 8'hFF) begin
                  r_j     <= 8'd0;
                  r_k     <= 2'd0;
                  r_state <= S_RD_I;
               end
            end
            S_RD_I: r_state <= S_WAIT_I;
            S_WAIT_I: begin
               r_si     <= r_rdata;
               r_j_next <= r_j + r_rdata + w_kb;
               r_state  <= S_RD_J;
            end
            S_RD_J: begin
               r_j     <= r_j_next;
               r_state <= S_WAIT_J;
            end
            S_WAIT_J: begin
               r_sj    <= r_rdata;
               r_state <= S_WR_I;
            end
            S_WR_I: r_state <= S_WR_J;
            S_WR_J: begin
               if (r_i == 8'hFF) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_i     <= r_i + 8'd1;
                  r_k     <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
                  r_state <= S_RD_I;
               end
            end
            default: r_state <= S_DONE;
         endcase
      end
   end

   assign HEX0 = 7'h7F;
   assign HEX1 = 7'h7F;
   assign HEX2 = 7'h7F;
   assign HEX3 = 7'h7F;
   assign HEX4 = 7'h7F;
   assign HEX5 = 7'h7F;
   assign LEDR = {9'b0, r_done};

endmodule

// File: tb/tb_arc4_ksa_top.sv
// tb/tb_arc4_ksa_top.sv - scoreboard bench for arc4_ksa_top
module tb_arc4_ksa_top;

   logic       clk = 1'b0;
   logic [3:0] key = 4'b1000;
   logic [9:0] sw  = 10'h000;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
   logic [9:0] ledr;

   always #10 clk = ~clk;

   arc4_ksa_top dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .SW       (sw),
      .HEX0     (hex0),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3),
      .HEX4     (hex4),
      .HEX5     (hex5),
      .LEDR     (ledr)
   );

   // kind 0: s_mem[idx]==exp, kind 1: LEDR[0]==exp, kind 2: count of value idx in s_mem == exp
   typedef struct {
      int    kind;
      int    idx;
      int    exp;
      string name;
   } item_t;

   item_t      q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc_cnt = 0;
   logic [7:0] gold [256];

   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic build_gold(input logic [9:0] s);
      logic [7:0] kb [3];
      logic [7:0] j;
      logic [7:0] t;
      kb[0] = 8'h00;
      kb[1] = {6'b0, s[9:8]};
      kb[2] = s[7:0];
      for (int i = 0; i < 256; i++) gold[i] = i[7:0];
      j = 8'd0;
      for (int i = 0; i < 256; i++) begin
         j       = j + gold[i] + kb[i % 3];
         t       = gold[i];
         gold[i] = gold[j];
         gold[j] = t;
      end
   endtask

   task automatic push_mem(input string name, input int idx, input int exp);
      q.push_back('{kind: 0, idx: idx, exp: exp, name: name});
   endtask

   task automatic push_led(input string name, input int exp);
      q.push_back('{kind: 1, idx: 0, exp: exp, name: name});
   endtask

   task automatic push_gold(input string name);
      for (int i = 0; i < 256; i++) push_mem($sformatf("%s_s%0d", name, i), i, int'(gold[i]));
   endtask

   task automatic push_perm(input string name);
      for (int v = 0; v < 256; v++) q.push_back('{kind: 2, idx: v, exp: 1, name: $sformatf("%s_v%0d", name, v)});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() > 0) begin
         chk({name, "_drain"}, q.size(), 0);
         q.delete();
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      key[3]  = 1'b0;
      cyc_cnt = 0;
   endtask

   task automatic wait_done(input string name);
      while (ledr[0] !== 1'b1 && cyc_cnt < 2000) begin
         @(posedge clk);
         #1;
      end
      chk({name, "_done"}, int'(ledr[0]), 1);
      n_tests++;
      if (cyc_cnt < 1791 || cyc_cnt > 1793) begin
         n_fail++;
         $display("FAIL %s_latency: actual %0d cycles required 1792 (+/-1)", name, cyc_cnt);
      end
   endtask

   // Scoreboard monitor: compares every queued expectation against the DUT.
   initial begin : monitor
      item_t it;
      int    c;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            it = q.pop_front();
            case (it.kind)
               0: chk(it.name, int'(dut.s_mem[it.idx]), it.exp);
               1: chk(it.name, int'(ledr[0]), it.exp);
               default: begin
                  c = 0;
                  for (int v = 0; v < 256; v++) if (dut.s_mem[v] == 8'(it.idx)) c++;
                  chk(it.name, c, it.exp);
               end
            endcase
         end
      end
   end

   // Static outputs checked on every cycle.
   always @(negedge clk) begin
      chk("hex_blank", (hex0 == 7'h7F && hex1 == 7'h7F && hex2 == 7'h7F &&
                        hex3 == 7'h7F && hex4 == 7'h7F && hex5 == 7'h7F) ? 1 : 0, 1);
      chk("ledr_hi", int'(ledr[9:1]), 0);
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      // Test 1: key 00 00 00
      key = 4'b1000;
      sw  = 10'h000;
      repeat (3) @(negedge clk);
      push_led("reset_led", 0);
      drain("reset");
      release_reset();

      repeat (257) @(posedge clk);
      for (int i = 0; i < 256; i++) push_mem($sformatf("init_s%0d", i), i, i);
      push_led("init_led", 0);
      drain("init");

      // i=0,1,2 iterations done after 274 edges; next write is at edge 279
      repeat (19) @(posedge clk);
      push_mem("iter2_s0", 0, 0);
      push_mem("iter2_s1", 1, 1);
      push_mem("iter2_s2", 2, 3);
      push_mem("iter2_s3", 3, 2);
      drain("iter2");

      wait_done("k000");
      build_gold(10'h000);
      push_gold("k000");
      push_led("k000_led", 1);
      drain("k000");

      repeat (1000) @(posedge clk);
      push_gold("k000_stable");
      push_led("k000_stable_led", 1);
      drain("k000_stable");

      // Test 2: key 00 03 3C; reset taken while done=1
      @(negedge clk);
      key[3] = 1'b1;
      sw     = 10'h33C;
      @(negedge clk);
      push_led("done_drop", 0);
      drain("done_drop");
      release_reset();
      wait_done("k33c");
      build_gold(10'h33C);
      push_gold("k33c");
      push_perm("k33c_perm");
      drain("k33c");

      // Test 3: start with key 0x155, abort mid-KSA, finish with key 0x3FF
      @(negedge clk);
      key[3] = 1'b1;
      sw     = 10'h155;
      @(negedge clk);
      release_reset();
      repeat (800) @(posedge clk);
      @(negedge clk);
      key[3] = 1'b1;
      sw     = 10'h3FF;
      @(negedge clk);
      push_led("midrst_led", 0);
      drain("midrst");
      release_reset();
      wait_done("k3ff");
      build_gold(10'h3FF);
      push_gold("k3ff");
      push_perm("k3ff_perm");
      drain("k3ff");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
